// File: rtl/mont_pkg.sv
// Shared types for the Montgomery modular-exponentiation controller.
//   state_t   : controller FSM states
//   op_t      : which multiplication is currently in flight
//   idx_width : width of the exponent bit index for a given exponent length
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_PRE  = 2'd0,  // X -> Montgomery domain: MM(X, R^2)
    OP_SQ   = 2'd1,  // acc = MM(acc, acc)
    OP_MUL  = 2'd2,  // acc = MM(acc, xm)
    OP_POST = 2'd3   // leave Montgomery domain: MM(acc, 1)
  } op_t;

  // Index width is $clog2(EXP_WIDTH), kept at least 1 so a 1-bit exponent
  // still gets a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_EXP_WIDTH = 512;
  localparam int DEFAULT_IDX_WIDTH = idx_width(DEFAULT_EXP_WIDTH);

endpackage

// File: rtl/mont_exp_scanner.sv
// Exponent scanner: holds the latched exponent and walks it MSB first.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture e and set the index to the MSB
//   dec        : step the index one bit toward the LSB
//   e          : exponent to capture
//   cur_bit    : exponent bit at the current index
//   last_bit   : current index is bit 0
module mont_exp_scanner
  import mont_pkg::*;
#(
  parameter int EXP_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 dec,
  input  logic [EXP_WIDTH-1:0] e,
  output logic                 cur_bit,
  output logic                 last_bit
);

  localparam int IDX_W = idx_width(EXP_WIDTH);

  logic [EXP_WIDTH-1:0] e_reg;
  logic [IDX_W-1:0]     idx_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_reg   <= '0;
      idx_reg <= '0;
    end else if (load) begin
      e_reg   <= e;
      idx_reg <= IDX_W'(EXP_WIDTH - 1);
    end else if (dec) begin
      idx_reg <= idx_reg - 1'b1;
    end
  end

  assign cur_bit  = e_reg[idx_reg];
  assign last_bit = (idx_reg == '0);

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external Montgomery
// multiplier through a start/done handshake. Computes result = X^E mod M.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : request, sampled only in IDLE
//   in_x/in_e/in_m      : base, exponent, odd modulus
//   in_r/in_r2          : R mod M and R^2 mod M, R = 2^WIDTH
//   result, done, busy  : final value, one-cycle completion pulse, activity
//   mm_start/a/b/m      : multiplier request pulse and registered operands
//   mm_result, mm_done  : multiplier product and its one-cycle valid pulse
module mont_modexp_ctrl
  import mont_pkg::*;
#(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  op_t              op_reg, op_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] r2_reg, r2_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] xm_reg, xm_next;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] opa_next, opb_next;
  logic             load, dec;
  logic             cur_bit, last_bit;

  mont_exp_scanner #(
    .EXP_WIDTH(EXP_WIDTH)
  ) u_scanner (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .dec     (dec),
    .e       (in_e),
    .cur_bit (cur_bit),
    .last_bit(last_bit)
  );

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    x_next      = x_reg;
    r2_next     = r2_reg;
    acc_next    = acc_reg;
    xm_next     = xm_reg;
    result_next = result;
    load        = 1'b0;
    dec         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          x_next     = in_x;
          r2_next    = in_r2;
          acc_next   = in_r;    // Montgomery form of 1
          op_next    = OP_PRE;
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (mm_done) begin
          state_next = ISSUE;
          case (op_reg)
            OP_PRE: begin
              xm_next = mm_result;
              op_next = OP_SQ;
            end
            OP_SQ, OP_MUL: begin
              acc_next = mm_result;
              // After a square, a set bit still needs its multiply at the
              // same index; only then does the scan move on.
              if (op_reg == OP_SQ && cur_bit) begin
                op_next = OP_MUL;
              end else if (last_bit) begin
                op_next = OP_POST;
              end else begin
                dec     = 1'b1;
                op_next = OP_SQ;
              end
            end
            default: begin
              result_next = mm_result;
              state_next  = DONE;
            end
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands for the next request come from the next-state values, so the
  // product just captured feeds straight into the following multiplication.
  always_comb begin
    opa_next = acc_next;
    opb_next = acc_next;
    case (op_next)
      OP_PRE: begin
        opa_next = x_next;
        opb_next = r2_next;
      end
      OP_MUL:  opb_next = xm_next;
      OP_POST: opb_next = ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= OP_PRE;
      x_reg     <= '0;
      r2_reg    <= '0;
      acc_reg   <= '0;
      xm_reg    <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mm_start  <= 1'b0;
      mm_a      <= '0;
      mm_b      <= '0;
      mm_m      <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      x_reg     <= x_next;
      r2_reg    <= r2_next;
      acc_reg   <= acc_next;
      xm_reg    <= xm_next;
      result    <= result_next;
      done      <= (state_next == DONE);
      busy      <= (state_next != IDLE);
      mm_start  <= (state_next == ISSUE);
      if (load) begin
        mm_m <= in_m;
      end
      // Operands only move on entry to ISSUE, keeping them steady while
      // the multiplier works.
      if (state_next == ISSUE) begin
        mm_a <= opa_next;
        mm_b <= opb_next;
      end
    end
  end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Directed bench for mont_modexp_ctrl with WIDTH=8, EXP_WIDTH=4, M=13,
// R mod M = 9, R^2 mod M = 3, and a behavioural Montgomery multiplier with
// configurable latency.
module tb_mont_modexp_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_x = '0;
  logic [3:0] in_e = '0;
  logic [7:0] in_m = 8'd13;
  logic [7:0] in_r = 8'd9;
  logic [7:0] in_r2 = 8'd3;
  logic [7:0] result;
  logic       done, busy, mm_start;
  logic [7:0] mm_a, mm_b, mm_m;
  logic [7:0] mm_result;
  logic       mm_done;

  always #5 clk = ~clk;

  mont_modexp_ctrl #(.WIDTH(8), .EXP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  // Reference Montgomery product: the r in [0,m) with r*256 == a*b (mod m).
  function automatic logic [7:0] mont_mul(input int a, input int b, input int m);
    if (m < 2) return 8'hff;
    for (int r = 0; r < m; r++)
      if (((r * 256) % m) == ((a * b) % m)) return 8'(r);
    return 8'hff;
  endfunction

  // Behavioural multiplier; deliberately ignores reset so a stale done can
  // reach the controller after a mid-operation reset.
  int         lat = 3;
  int         mdl_cnt = 0;
  logic       mdl_done = 1'b0;
  logic [7:0] mdl_result = '0;
  logic [7:0] op_a = '0, op_b = '0, op_m = '0;
  logic       inj_done = 1'b0;
  logic [7:0] inj_result = '0;

  assign mm_done   = mdl_done | inj_done;
  assign mm_result = inj_done ? inj_result : mdl_result;

  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (mm_start) begin
      mdl_cnt <= lat;
      op_a    <= mm_a;
      op_b    <= mm_b;
      op_m    <= mm_m;
    end else if (mdl_cnt == 1) begin
      mdl_done   <= 1'b1;
      mdl_result <= mont_mul(int'(op_a), int'(op_b), int'(op_m));
      mdl_cnt    <= 0;
    end else if (mdl_cnt > 1) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  // Cumulative activity monitor, sampled on the falling edge.
  int         total_pulses = 0;
  int         total_done = 0;
  int         stab_bad = 0;
  logic       in_flight = 1'b0;
  logic [7:0] cap_a = '0, cap_b = '0, cap_m = '0;

  always @(negedge clk) begin
    if (reset) begin
      in_flight = 1'b0;
    end else begin
      if (done) total_done++;
      if (mm_start) begin
        total_pulses++;
        cap_a = mm_a; cap_b = mm_b; cap_m = mm_m;
        in_flight = 1'b1;
      end else if (in_flight) begin
        if (mm_a != cap_a || mm_b != cap_b || mm_m != cap_m) stab_bad++;
        if (mm_done) in_flight = 1'b0;
      end
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input int act, input int expv);
    vec_cnt++;
    if (act != expv) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // One complete request. disturb>0 re-pulses start with other operands that
  // many cycles after acceptance; spur injects a mm_done during DONE.
  task automatic run_vec(input string name, input logic [7:0] x, input logic [3:0] e,
                         input int l, input logic [7:0] exp_res, input int exp_pulses,
                         input int disturb, input bit spur);
    int p0, d0, s0, cyc;
    bit got;
    lat = l;
    p0 = total_pulses; d0 = total_done; s0 = stab_bad;
    @(negedge clk);
    in_x = x; in_e = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".busy_accept"}, int'(busy), 1);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 6000) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (disturb != 0 && cyc == disturb) begin
          in_x = 8'd7; in_e = 4'd11; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    chk({name, ".done_seen"}, int'(got), 1);
    chk({name, ".result"}, int'(result), int'(exp_res));
    chk({name, ".busy_in_done"}, int'(busy), 1);
    if (spur) begin
      inj_result = 8'd5; inj_done = 1'b1;
    end
    @(negedge clk);
    inj_done = 1'b0;
    chk({name, ".done_falls"}, int'(done), 0);
    chk({name, ".busy_falls"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    chk({name, ".result_held"}, int'(result), int'(exp_res));
    chk({name, ".idle_busy"}, int'(busy), 0);
    chk({name, ".mm_pulses"}, total_pulses - p0, exp_pulses);
    chk({name, ".done_pulses"}, total_done - d0, 1);
    chk({name, ".operand_stable"}, stab_bad - s0, 0);
    $display("vec %s: X=%0d E=%0d L=%0d result=%0d pulses=%0d cycles=%0d",
             name, x, e, l, result, total_pulses - p0, cyc);
  endtask

  typedef struct {
    string      name;
    logic [7:0] x;
    logic [3:0] e;
    int         lat;
    logic [7:0] res;
    int         pulses;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int p0, bad;
    tbl[0] = '{"x2_e5",     8'd2, 4'd5,  3,   8'd6, 8};
    tbl[1] = '{"x2_e15",    8'd2, 4'd15, 3,   8'd8, 10};
    tbl[2] = '{"x2_e0",     8'd2, 4'd0,  3,   8'd1, 6};
    tbl[3] = '{"x7_e11_l1", 8'd7, 4'd11, 1,   8'd2, 9};
    tbl[4] = '{"x7_e11_l40", 8'd7, 4'd11, 40, 8'd2, 9};
    tbl[5] = '{"x7_e11_l200", 8'd7, 4'd11, 200, 8'd2, 9};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.result", int'(result), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.mm_start", int'(mm_start), 0);
    chk("rst.mm_a", int'(mm_a), 0);
    chk("rst.mm_m", int'(mm_m), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_vec(tbl[i].name, tbl[i].x, tbl[i].e, tbl[i].lat, tbl[i].res, tbl[i].pulses, 0, 1'b0);

    // start re-pulsed with other operands while busy
    run_vec("start_in_wait", 8'd2, 4'd5, 3, 8'd6, 8, 4, 1'b0);

    // spurious mm_done during DONE
    run_vec("spur_in_done", 8'd2, 4'd15, 3, 8'd8, 10, 0, 1'b1);

    // spurious mm_done in IDLE
    p0 = total_pulses;
    @(negedge clk);
    inj_result = 8'd5; inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_idle.result", int'(result), 8);
    chk("spur_idle.busy", int'(busy), 0);
    chk("spur_idle.mm_pulses", total_pulses - p0, 0);
    $display("vec spur_idle: result=%0d busy=%0d", result, busy);

    // reset while waiting on the multiplier, then a stale mm_done
    lat = 10;
    @(negedge clk);
    in_x = 8'd2; in_e = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst.mm_start", int'(mm_start), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk("midrst.result", int'(result), 0);
    chk("midrst.mm_a", int'(mm_a), 0);
    chk("midrst.mm_b", int'(mm_b), 0);
    chk("midrst.mm_m", int'(mm_m), 0);
    @(negedge clk);
    reset = 1'b0;
    p0 = total_pulses;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done || mm_start) bad++;
    end
    chk("midrst.quiet_cycles", bad, 0);
    chk("midrst.mm_pulses", total_pulses - p0, 0);
    chk("midrst.result_zero", int'(result), 0);
    $display("vec midrst: quiet check over 20 cycles, active=%0d", bad);
    run_vec("after_reset", 8'd2, 4'd5, 3, 8'd6, 8, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
